// File: rtl/br_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: entry record, pointer width and redirect helper.
package brq_pkg;

   // Security domain tag of a branch, matching the predictor-side domain encoding.
   typedef logic [1:0] domain_t;

   localparam int unsigned BRQ_DEPTH  = 8;
   localparam int unsigned BRQ_PTR_W  = $clog2(BRQ_DEPTH);
   localparam int unsigned BRQ_IDX_W  = 32;
   localparam int unsigned BRQ_TARG_W = 32;

   typedef struct packed {
      logic [BRQ_IDX_W-1:0]  idx;
      logic                  taken;
      logic [BRQ_TARG_W-1:0] targ;
      domain_t               domain;
   } brq_entry_t;

   function automatic logic [BRQ_TARG_W-1:0] redirect_target(input logic taken,
                                                             input logic [BRQ_TARG_W-1:0] targ);
      if (taken) begin
         return targ;
      end else begin
         return {BRQ_TARG_W{1'b0}};
      end
   endfunction

endpackage

// File: rtl/br_resolve_queue_if.sv
// Prediction, resolve and training-update signals between predictor, execute and the resolve queue.
interface brq_if
   import brq_pkg::*;
#(
   parameter int unsigned DEPTH  = BRQ_DEPTH,
   parameter int unsigned IDX_W  = BRQ_IDX_W,
   parameter int unsigned TARG_W = BRQ_TARG_W
);
   logic                     pred_valid_i;
   logic                     pred_ready_o;
   logic [IDX_W-1:0]         pred_idx_i;
   logic                     pred_taken_i;
   logic [TARG_W-1:0]        pred_targ_i;
   domain_t                  pred_domain_i;
   logic                     res_valid_i;
   logic                     res_taken_i;
   logic [TARG_W-1:0]        res_targ_i;
   logic                     flush_i;
   logic                     upd_valid_o;
   logic [IDX_W-1:0]         upd_idx_o;
   logic                     br_result_o;
   logic                     correct_o;
   domain_t                  upd_domain_o;
   logic                     mispredict_o;
   logic [TARG_W-1:0]        redirect_targ_o;
   logic [$clog2(DEPTH):0]   count_o;

   modport slave (
      input  pred_valid_i, pred_idx_i, pred_taken_i, pred_targ_i, pred_domain_i,
      input  res_valid_i, res_taken_i, res_targ_i, flush_i,
      output pred_ready_o, upd_valid_o, upd_idx_o, br_result_o, correct_o,
      output upd_domain_o, mispredict_o, redirect_targ_o, count_o
   );

   modport master (
      output pred_valid_i, pred_idx_i, pred_taken_i, pred_targ_i, pred_domain_i,
      output res_valid_i, res_taken_i, res_targ_i, flush_i,
      input  pred_ready_o, upd_valid_o, upd_idx_o, br_result_o, correct_o,
      input  upd_domain_o, mispredict_o, redirect_targ_o, count_o
   );
endinterface

// File: rtl/br_resolve_queue_fifo.sv
// Circular store of in-flight predictions; head/tail wrap naturally, full/empty come from the count.
module brq_fifo
   import brq_pkg::*;
#(
   parameter int unsigned DEPTH = BRQ_DEPTH
)(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     clear_i,
   input  brq_entry_t               wr_entry_i,
   output brq_entry_t               rd_entry_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   brq_entry_t        mem_r [DEPTH];
   logic [PTR_W-1:0]  head_r;
   logic [PTR_W-1:0]  tail_r;
   logic [CNT_W-1:0]  count_r;

   // Pointer and occupancy tracking; clear abandons every entry at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else if (clear_i) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else begin
         if (push_i) begin
            tail_r <= tail_r + PTR_W'(1);
         end
         if (pop_i) begin
            head_r <= head_r + PTR_W'(1);
         end
         case ({push_i, pop_i})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage written at the tail.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (push_i && !clear_i) begin
         mem_r[tail_r] <= wr_entry_i;
      end
   end

   assign rd_entry_o = mem_r[head_r];
   assign count_o    = count_r;
   assign full_o     = (count_r == CNT_W'(DEPTH));
   assign empty_o    = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/br_resolve_queue.sv
// In-order queue of in-flight branch predictions producing registered training updates and redirects.
// Build option: define BRQ_TARGET_CHECK_EN to require a target match for taken branches to count as correct.
module br_resolve_queue
   import brq_pkg::*;
#(
   parameter int unsigned DEPTH  = BRQ_DEPTH,
   parameter int unsigned IDX_W  = BRQ_IDX_W,
   parameter int unsigned TARG_W = BRQ_TARG_W
)(
   input  logic   clk_i,
   input  logic   rst_i,
   brq_if.slave   brq
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   brq_entry_t        wr_entry_s;
   brq_entry_t        head_entry_s;
   logic [CNT_W-1:0]  count_s;
   logic              full_s;
   logic              empty_s;
   logic              res_fire_s;
   logic              correct_s;
   logic              mispredict_s;
   logic              clear_s;
   logic              push_s;
   logic              pop_s;

   logic              upd_valid_r;
   logic [IDX_W-1:0]  upd_idx_r;
   logic              br_result_r;
   logic              correct_r;
   domain_t           upd_domain_r;
   logic              mispredict_r;
   logic [TARG_W-1:0] redirect_targ_r;

   brq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (push_s),
      .pop_i      (pop_s),
      .clear_i    (clear_s),
      .wr_entry_i (wr_entry_s),
      .rd_entry_o (head_entry_s),
      .count_o    (count_s),
      .full_o     (full_s),
      .empty_o    (empty_s)
   );

   // Resolve compare and queue control; a squash or flush outranks any same-cycle enqueue or pop.
   always_comb begin
      wr_entry_s        = '0;
      wr_entry_s.idx    = brq.pred_idx_i;
      wr_entry_s.taken  = brq.pred_taken_i;
      wr_entry_s.targ   = brq.pred_targ_i;
      wr_entry_s.domain = brq.pred_domain_i;
      res_fire_s        = brq.res_valid_i && !empty_s;
      correct_s         = 1'b0;
      if (brq.res_taken_i == head_entry_s.taken) begin
`ifdef BRQ_TARGET_CHECK_EN
         correct_s = !brq.res_taken_i || (brq.res_targ_i == head_entry_s.targ);
`else
         correct_s = 1'b1;
`endif
      end else begin
         correct_s = 1'b0;
      end
      mispredict_s = res_fire_s && !correct_s;
      clear_s      = brq.flush_i || mispredict_s;
      push_s       = brq.pred_valid_i && !full_s && !clear_s;
      pop_s        = res_fire_s && !clear_s;
   end

   // Training update and redirect registers; valid strobes last one cycle, payload holds until the next resolve.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         upd_valid_r     <= 1'b0;
         upd_idx_r       <= {IDX_W{1'b0}};
         br_result_r     <= 1'b0;
         correct_r       <= 1'b0;
         upd_domain_r    <= '0;
         mispredict_r    <= 1'b0;
         redirect_targ_r <= {TARG_W{1'b0}};
      end else begin
         upd_valid_r  <= res_fire_s;
         mispredict_r <= mispredict_s;
         if (res_fire_s) begin
            upd_idx_r       <= head_entry_s.idx;
            br_result_r     <= brq.res_taken_i;
            correct_r       <= correct_s;
            upd_domain_r    <= head_entry_s.domain;
            redirect_targ_r <= redirect_target(brq.res_taken_i, brq.res_targ_i);
         end
      end
   end

   assign brq.pred_ready_o    = !full_s;
   assign brq.count_o         = count_s;
   assign brq.upd_valid_o     = upd_valid_r;
   assign brq.upd_idx_o       = upd_idx_r;
   assign brq.br_result_o     = br_result_r;
   assign brq.correct_o       = correct_r;
   assign brq.upd_domain_o    = upd_domain_r;
   assign brq.mispredict_o    = mispredict_r;
   assign brq.redirect_targ_o = redirect_targ_r;

endmodule
